// File: rtl/trace_pkg.sv
//------------------------------------------------------------------------------
// trace_pkg : shared types and constant helpers for the trace checker
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Bit width for a counter/index over v values, never less than 1.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Lowest bit of channel c in a packed vector of w-bit channels.
  function automatic int chan_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_table.sv
//------------------------------------------------------------------------------
// trace_table : expected-vector store, synchronous write, asynchronous read
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_table
  import trace_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WIDTH  = 18
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/trace_checker.sv
//------------------------------------------------------------------------------
// trace_checker : cycle-driven scoreboard comparing observed channels against
//                 a preloaded table of masked expected vectors
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_checker
  import trace_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int START_DELAY = 1,
  parameter int STRIDE      = 1,
  parameter int CHAN_W      = clog2_min1(CHANNELS)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       load_en_i,
  input  logic [ADDR_W-1:0]          load_addr_i,
  input  logic [CHANNELS*DATA_W-1:0] load_exp_i,
  input  logic [CHANNELS-1:0]        load_mask_i,
  input  logic                       start_i,
  input  logic [ADDR_W:0]            num_checks_i,
  input  logic [CHANNELS*DATA_W-1:0] obs_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic [ADDR_W:0]            fail_count_o,
  output logic [ADDR_W-1:0]          first_fail_idx_o,
  output logic [CHAN_W-1:0]          first_fail_chan_o,
  output logic [DATA_W-1:0]          first_fail_obs_o,
  output logic [DATA_W-1:0]          first_fail_exp_o
);

  localparam int EXP_W = CHANNELS * DATA_W;
  localparam int ROW_W = EXP_W + CHANNELS;
  localparam int DLY_W = clog2_min1(START_DELAY + 1);
  localparam int STR_W = clog2_min1(STRIDE);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [STR_W-1:0]    str_q, str_d;
  logic [ADDR_W:0]     fc_q, fc_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ADDR_W-1:0]   ff_idx_q, ff_idx_d;
  logic [CHAN_W-1:0]   ff_chan_q, ff_chan_d;
  logic [DATA_W-1:0]   ff_obs_q, ff_obs_d;
  logic [DATA_W-1:0]   ff_exp_q, ff_exp_d;

  logic                busy;
  logic [ROW_W-1:0]    row;
  logic [EXP_W-1:0]    rd_exp;
  logic [CHANNELS-1:0] rd_mask;
  logic [CHANNELS-1:0] mism;
  logic                entry_fail;
  logic [CHAN_W-1:0]   hit_chan;
  logic [DATA_W-1:0]   hit_obs;
  logic [DATA_W-1:0]   hit_exp;
  logic [ADDR_W:0]     fc_next;
  logic [ADDR_W:0]     n_req;

  assign busy = (state_q == S_WAIT) || (state_q == S_CHECK);

  // Writes are gated by busy so the table is frozen for the whole run.
  trace_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ROW_W)
  ) u_table (
    .clk_i   (clk_i),
    .we_i    (load_en_i && !busy),
    .waddr_i (load_addr_i),
    .wdata_i ({load_mask_i, load_exp_i}),
    .raddr_i (idx_q),
    .rdata_o (row)
  );

  assign rd_exp  = row[EXP_W-1:0];
  assign rd_mask = row[ROW_W-1:EXP_W];

  // Case inequality so X/Z on a checked channel is reported as a mismatch.
  always_comb begin
    mism     = '0;
    hit_chan = '0;
    hit_obs  = '0;
    hit_exp  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mism[c] = rd_mask[c] &&
                (obs_i[chan_lsb(c, DATA_W) +: DATA_W] !== rd_exp[chan_lsb(c, DATA_W) +: DATA_W]);
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (mism[c]) begin
        hit_chan = CHAN_W'(c);
        hit_obs  = obs_i[chan_lsb(c, DATA_W) +: DATA_W];
        hit_exp  = rd_exp[chan_lsb(c, DATA_W) +: DATA_W];
      end
    end
  end

  assign entry_fail = |mism;
  assign fc_next    = !entry_fail ? fc_q : ((&fc_q) ? fc_q : fc_q + 1'b1);
  assign n_req      = (num_checks_i > DEPTH_N) ? DEPTH_N : num_checks_i;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    dly_d     = dly_q;
    str_d     = str_q;
    fc_d      = fc_q;
    done_d    = done_q;
    pass_d    = pass_q;
    ff_idx_d  = ff_idx_q;
    ff_chan_d = ff_chan_q;
    ff_obs_d  = ff_obs_q;
    ff_exp_d  = ff_exp_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          n_d       = n_req;
          idx_d     = '0;
          str_d     = '0;
          fc_d      = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          ff_idx_d  = '0;
          ff_chan_d = '0;
          ff_obs_d  = '0;
          ff_exp_d  = '0;
          if (n_req == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (START_DELAY == 0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_WAIT;
            dly_d   = DLY_W'(START_DELAY);
          end
        end
      end
      S_WAIT: begin
        dly_d = dly_q - 1'b1;
        if (dly_q <= DLY_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (str_q == '0) begin
          fc_d = fc_next;
          // fail count still zero means this is the run's first failing entry
          if (entry_fail && (fc_q == '0)) begin
            ff_idx_d  = idx_q;
            ff_chan_d = hit_chan;
            ff_obs_d  = hit_obs;
            ff_exp_d  = hit_exp;
          end
          if ({1'b0, idx_q} == n_q - (ADDR_W+1)'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (fc_next == '0);
          end else begin
            idx_d = idx_q + 1'b1;
            str_d = STR_W'(STRIDE - 1);
          end
        end else begin
          str_d = str_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      dly_q     <= '0;
      str_q     <= '0;
      fc_q      <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      ff_idx_q  <= '0;
      ff_chan_q <= '0;
      ff_obs_q  <= '0;
      ff_exp_q  <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      str_q     <= str_d;
      fc_q      <= fc_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      ff_idx_q  <= ff_idx_d;
      ff_chan_q <= ff_chan_d;
      ff_obs_q  <= ff_obs_d;
      ff_exp_q  <= ff_exp_d;
    end
  end

  assign busy_o            = busy;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign fail_count_o      = fc_q;
  assign first_fail_idx_o  = ff_idx_q;
  assign first_fail_chan_o = ff_chan_q;
  assign first_fail_obs_o  = ff_obs_q;
  assign first_fail_exp_o  = ff_exp_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_checker.sv
//------------------------------------------------------------------------------
// tb_trace_checker : directed self-checking bench for trace_checker
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trace_checker;

  localparam int DATA_W      = 8;
  localparam int CHANNELS    = 2;
  localparam int DEPTH       = 32;
  localparam int ADDR_W      = 5;
  localparam int START_DELAY = 1;
  localparam int STRIDE      = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_exp = '0;
  logic [1:0]  load_mask = '0;
  logic        start = 1'b0;
  logic [5:0]  num_checks = '0;
  logic [15:0] obs = '0;
  logic        busy, done, pass;
  logic [5:0]  fail_count;
  logic [4:0]  ff_idx;
  logic        ff_chan;
  logic [7:0]  ff_obs, ff_exp;

  logic [15:0] obs_tab [32];
  logic        ld_pend = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [15:0] ld_exp = '0;
  logic [1:0]  ld_mask = '0;

  int n_tests = 0;
  int n_fail  = 0;

  trace_checker #(
    .DATA_W      (DATA_W),
    .CHANNELS    (CHANNELS),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .START_DELAY (START_DELAY),
    .STRIDE      (STRIDE)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .load_en_i         (load_en),
    .load_addr_i       (load_addr),
    .load_exp_i        (load_exp),
    .load_mask_i       (load_mask),
    .start_i           (start),
    .num_checks_i      (num_checks),
    .obs_i             (obs),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .fail_count_o      (fail_count),
    .first_fail_idx_o  (ff_idx),
    .first_fail_chan_o (ff_chan),
    .first_fail_obs_o  (ff_obs),
    .first_fail_exp_o  (ff_exp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] m);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 5'(a);
    load_exp  = {e1, e0};
    load_mask = m;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Accepts a run, feeds obs_tab[k] just ahead of each sample edge and checks
  // done rises on exactly the last sample edge. poke_k injects an ignored
  // start + table write; abort_k asserts reset after that many checks.
  task automatic do_run(input int n_req, input int n_eff, input int poke_k, input int abort_k);
    int gap;
    @(negedge clk);
    start      = 1'b1;
    num_checks = 6'(n_req);
    load_en    = ld_pend;
    load_addr  = ld_addr;
    load_exp   = ld_exp;
    load_mask  = ld_mask;
    obs        = obs_tab[0];
    @(posedge clk);
    #1;
    start   = 1'b0;
    load_en = 1'b0;
    ld_pend = 1'b0;
    if (n_eff == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_pass", 32'(pass), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      return;
    end
    check("run_busy", 32'(busy), 32'd1);
    for (int k = 0; k < n_eff; k++) begin
      if (k == abort_k) begin
        check("pre_reset_fc", 32'(fail_count), 32'(k));
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fc", 32'(fail_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      gap = (k == 0) ? START_DELAY + 1 : STRIDE;
      obs = obs_tab[k];
      if (k == poke_k) begin
        start      = 1'b1;
        num_checks = 6'd0;
        load_en    = 1'b1;
        load_addr  = 5'd5;
        load_exp   = obs_tab[5];
        load_mask  = 2'b11;
      end
      for (int g = 0; g < gap; g++) begin
        if (g == gap - 1 && k == n_eff - 1) check("done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start   = 1'b0;
        load_en = 1'b0;
      end
    end
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) obs_tab[i] = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_fc", 32'(fail_count), 32'd0);
    check("reset_ffinfo", {8'h0, ff_obs, ff_exp, 2'b0, ff_chan, ff_idx}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Pass case; entry1 is written in the same cycle as start.
    load(0, 8'd100, 8'd200, 2'b11);
    ld_pend = 1'b1; ld_addr = 5'd1; ld_exp = {8'd200, 8'd100}; ld_mask = 2'b11;
    obs_tab[0] = {8'd200, 8'd100};
    obs_tab[1] = {8'd200, 8'd100};
    do_run(2, 2, -1, -1);
    check("p_pass", 32'(pass), 32'd1);
    check("p_fc", 32'(fail_count), 32'd0);

    // Single mismatch on entry2 channel1.
    load(0, 8'd25, 8'd30, 2'b11);
    load(1, 8'd50, 8'd30, 2'b11);
    load(2, 8'd50, 8'd30, 2'b11);
    obs_tab[0] = {8'd30, 8'd25};
    obs_tab[1] = {8'd30, 8'd50};
    obs_tab[2] = {8'd31, 8'd50};
    do_run(3, 3, -1, -1);
    check("s_fc", 32'(fail_count), 32'd1);
    check("s_idx", 32'(ff_idx), 32'd2);
    check("s_chan", 32'(ff_chan), 32'd1);
    check("s_obs", 32'(ff_obs), 32'd31);
    check("s_exp", 32'(ff_exp), 32'd30);
    check("s_pass", 32'(pass), 32'd0);

    // Masked-out unknown channel, then the same entry fully checked.
    load(0, 8'd10, 8'hA5, 2'b01);
    obs_tab[0] = {8'hxx, 8'd10};
    do_run(1, 1, -1, -1);
    check("m_fc", 32'(fail_count), 32'd0);
    check("m_pass", 32'(pass), 32'd1);
    load(0, 8'd10, 8'hA5, 2'b11);
    do_run(1, 1, -1, -1);
    check("x_fc", 32'(fail_count), 32'd1);
    check("x_chan", 32'(ff_chan), 32'd1);
    check("x_pass", 32'(pass), 32'd0);

    // Multi-channel failure counts once per entry.
    load(0, 8'd125, 8'd75, 2'b11);
    load(1, 8'd13, 8'd3, 2'b11);
    obs_tab[0] = {8'd2, 8'd1};
    obs_tab[1] = {8'd4, 8'd13};
    do_run(2, 2, -1, -1);
    check("mc_fc", 32'(fail_count), 32'd2);
    check("mc_idx", 32'(ff_idx), 32'd0);
    check("mc_chan", 32'(ff_chan), 32'd0);
    check("mc_obs", 32'(ff_obs), 32'd1);
    check("mc_exp", 32'(ff_exp), 32'd125);

    // Zero-length run.
    do_run(0, 0, -1, -1);
    check("z_fc", 32'(fail_count), 32'd0);

    // Clamped run of 32 all-failing entries; a mid-run start and write must be ignored.
    for (int i = 0; i < 32; i++) begin
      load(i, 8'(i), 8'(i + 1), 2'b11);
      obs_tab[i] = {8'hEE, 8'(i)};
    end
    do_run(40, 32, 1, -1);
    check("c_fc", 32'(fail_count), 32'd32);
    check("c_idx", 32'(ff_idx), 32'd0);
    check("c_obs", 32'(ff_obs), 32'hEE);
    check("c_exp", 32'(ff_exp), 32'd1);

    // Reset after three failing checks, then rerun on the retained table.
    do_run(8, 8, -1, 3);
    check("r_idle_busy", 32'(busy), 32'd0);
    check("r_ffidx", 32'(ff_idx), 32'd0);
    for (int i = 0; i < 8; i++) obs_tab[i] = {8'(i + 1), 8'(i)};
    do_run(8, 8, -1, -1);
    check("r_pass", 32'(pass), 32'd1);
    check("r_fc", 32'(fail_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Synthesizable self-checking scoreboard that compares up to CHANNELS observed datapath values (regA, regB, pc, status flags, ...) against a preloaded table of expected vectors, one table entry per check slot.
- Sits beside the computer top level on simulation and FPGA-debug builds.
- Replaces fixed hand-timed checks with a parametrised, cycle-driven check sequencer.
- Adds per-entry don't-care masks and a latched first-failure record.

Parameters:
- DATA_W, 8: width of one observed channel.
- CHANNELS, 2: number of observed channels.
- DEPTH, 32: number of expected-vector entries.
- ADDR_W, $clog2(DEPTH): entry index width.
- START_DELAY, 1: cycles between start acceptance and the first check.
- STRIDE, 1: cycles between consecutive checks; must be >= 1.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- load_en, in, 1: write the expected-table entry at load_addr.
- load_addr, in, ADDR_W: entry index to write.
- load_exp, in, CHANNELS*DATA_W: expected values; channel c occupies bits [c*DATA_W +: DATA_W].
- load_mask, in, CHANNELS: 1 = check that channel, 0 = don't care.
- start, in, 1: single-cycle pulse that begins a run.
- num_checks, in, ADDR_W+1: number of entries to check; sampled with start.
- obs, in, CHANNELS*DATA_W: observed values, same packing as load_exp.
- busy, out, 1: a run is in progress.
- done, out, 1: run complete; held until the next accepted start or reset.
- pass, out, 1: done with zero failures.
- fail_count, out, ADDR_W+1: number of failing entries; saturates at all-ones.
- first_fail_idx, out, ADDR_W: index of the first failing entry.
- first_fail_chan, out, $clog2(CHANNELS) (minimum 1): lowest failing channel in that entry.
- first_fail_obs, out, DATA_W: observed value on that channel.
- first_fail_exp, out, DATA_W: expected value on that channel.

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE.
  - busy=0, done=0, pass=0, fail_count=0, all first_fail_* = 0, internal counters = 0.
  - The expected table and masks are NOT cleared.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE:
  - start=1 latches n = min(num_checks, DEPTH), clears fail_count and first_fail_*, and sets done=0, pass=0, busy=1.
  - If n=0: go directly to DONE on that same edge with done=1, pass=1, busy=0.
  - Otherwise go to WAIT with the delay counter set to START_DELAY.
- WAIT:
  - Decrement the delay counter each cycle.
  - Move to CHECK when it reaches 0; START_DELAY=0 enters CHECK immediately.
- CHECK:
  - Entry k samples obs at the rising edge START_DELAY+1+k*STRIDE cycles after the edge that accepted start.
  - The expected table has an asynchronous read indexed by the current entry counter.
  - Entry mismatch: any channel with mask=1 whose obs slice differs from its exp slice. An X or Z bit on a masked-in channel counts as a mismatch (case-equality semantics).
  - Masked-out channels are never compared.
  - Each mismatching entry increments fail_count by exactly 1, regardless of how many channels fail.
  - The first mismatching entry of the run latches first_fail_*. When several channels fail, the lowest channel index is recorded.
  - Between checks, a stride counter idles for STRIDE-1 cycles.
- Run completion:
  - On the edge that samples entry n-1: go to DONE, busy=0, done=1.
  - pass = (final fail_count == 0), registered on that same edge; it includes entry n-1's result.
- Boundary cases:
  - start while busy: ignored.
  - load_en while busy: write dropped, so the table stays stable for the whole run.
  - load_en while IDLE or DONE: one entry written per cycle.
  - load_en and start in the same cycle in IDLE/DONE: the write completes first and is visible to the run.
  - num_checks > DEPTH: clamped to DEPTH.
  - fail_count saturates at 2^(ADDR_W+1)-1; it never wraps.
  - reset mid-run: immediate return to IDLE with all outputs at their reset values. A later start reruns with the retained table.

Decomposition:
- Shared package trace_pkg holds:
  - the FSM state enum (IDLE, WAIT, CHECK, DONE);
  - the channel slice helper function;
  - clog2-with-minimum-1 constant helper.
- One natural sub-module: trace_table. It is a DEPTH x (CHANNELS*DATA_W + CHANNELS) register array with a synchronous write port and an asynchronous read port, no reset.
- The FSM, counters and compare logic live in trace_checker.

Test Plan:
- Pass case: CHANNELS=2, DATA_W=8. Load entry0=(100,200), entry1=(100,200), both masks 2'b11; n=2; drive obs=(100,200) -> done=1, pass=1, fail_count=0. done rises exactly START_DELAY+1+STRIDE cycles after the start edge.
- Single mismatch: entries (25,30), (50,30), (50,30); drive obs (50,31) at entry2 -> fail_count=1, first_fail_idx=2, first_fail_chan=1, first_fail_obs=31, first_fail_exp=30, pass=0.
- Mask and X handling:
  - Entry mask 2'b01 with obs channel1 = 8'hxx and channel0 matching -> no failure.
  - Same entry with mask 2'b11 -> fail_count=1.
- Multi-channel failure and counting: entries (125,75) and (13,3); both channels wrong in entry0, one channel wrong in entry1 -> fail_count=2, first_fail_idx=0, first_fail_chan=0.
- Edge inputs:
  - num_checks=0 -> done=1, pass=1 on the edge that accepted start.
  - num_checks=40 with DEPTH=32 -> exactly 32 checks performed.
  - A second start pulse mid-run has no effect.
- Reset mid-run:
  - Assert reset after 3 checks -> busy=0, done=0, fail_count=0 asynchronously.
  - Restart with an unchanged table and matching obs -> pass=1.
